// File: rtl/hevc_subpel_pkg.sv
// rtl/hevc_subpel_pkg.sv - taps, FSM states and width helpers; HEVC_SUBPEL_ROUND_CLIP_EN selects clipped sample output
package hevc_subpel_pkg;

    // Two's-complement 8-bit taps, tap k weights pixel j+k
    localparam logic [0:7][7:0] COEF_A = '{8'hFF, 8'h04, 8'hF6, 8'h3A, 8'h11, 8'hFB, 8'h01, 8'h00};
    localparam logic [0:7][7:0] COEF_B = '{8'hFF, 8'h04, 8'hF5, 8'h28, 8'h28, 8'hF5, 8'h04, 8'hFF};
    localparam logic [0:7][7:0] COEF_C = '{8'h00, 8'h01, 8'hFB, 8'h11, 8'h3A, 8'hF6, 8'h04, 8'hFF};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    function automatic int acc_w(input int bit_depth);
        return bit_depth + 8;
    endfunction

    function automatic int out_w(input int bit_depth);
`ifdef HEVC_SUBPEL_ROUND_CLIP_EN
        return bit_depth;
`else
        return 16 + 0 * bit_depth;
`endif
    endfunction

endpackage

// File: rtl/hevc_fir8.sv
// rtl/hevc_fir8.sv - one output column: the three 8-tap luma phases over eight samples (HEVC_SUBPEL_ROUND_CLIP_EN)
module hevc_fir8
    import hevc_subpel_pkg::*;
#(
    parameter int BIT_DEPTH = 8,
    parameter int OUT_W     = out_w(BIT_DEPTH)
) (
    input  logic [8*BIT_DEPTH-1:0] pix,
    output logic [OUT_W-1:0]       res_a,
    output logic [OUT_W-1:0]       res_b,
    output logic [OUT_W-1:0]       res_c
);

    localparam int ACC_W = acc_w(BIT_DEPTH);
    localparam logic signed [ACC_W-1:0] MAX_PIX = ACC_W'((1 << BIT_DEPTH) - 1);

    function automatic logic signed [ACC_W-1:0] filt(input logic [0:7][7:0] coef,
                                                     input logic [8*BIT_DEPTH-1:0] p);
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] c;
        logic signed [ACC_W-1:0] s;
        acc = '0;
        for (int k = 0; k < 8; k++) begin
            c   = {{(ACC_W-8){coef[k][7]}}, coef[k]};
            s   = {{(ACC_W-BIT_DEPTH){1'b0}}, p[k*BIT_DEPTH +: BIT_DEPTH]};
            acc = acc + c * s;
        end
        return acc;
    endfunction

    function automatic logic [OUT_W-1:0] post(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] r;
`ifdef HEVC_SUBPEL_ROUND_CLIP_EN
        r = (acc + ACC_W'(32)) >>> 6;
        if (r[ACC_W-1])
            return '0;
        else if (r > MAX_PIX)
            return OUT_W'(MAX_PIX);
        else
            return OUT_W'(r);
`else
        // Normalise to the 14-bit-precision intermediate regardless of bit depth
        r = acc >>> (BIT_DEPTH - 8);
        return OUT_W'(r);
`endif
    endfunction

    assign res_a = post(filt(COEF_A, pix));
    assign res_b = post(filt(COEF_B, pix));
    assign res_c = post(filt(COEF_C, pix));

endmodule

// File: rtl/hevc_subpel_row_engine.sv
// rtl/hevc_subpel_row_engine.sv - streaming HEVC luma sub-pel row engine; output format set by HEVC_SUBPEL_ROUND_CLIP_EN
module hevc_subpel_row_engine
    import hevc_subpel_pkg::*;
#(
    parameter int BLK_W     = 8,
    parameter int BLK_H     = 8,
    parameter int BIT_DEPTH = 8,
    localparam int ROWS     = BLK_H + 7,
    localparam int RW       = $clog2(BLK_H + 7),
    localparam int OUT_W    = out_w(BIT_DEPTH),
    localparam int IN_W     = (BLK_W + 7) * BIT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic [RW-1:0]          row_idx,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_row,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RW-1:0]          out_row,
    output logic [BLK_W*OUT_W-1:0] out_a,
    output logic [BLK_W*OUT_W-1:0] out_b,
    output logic [BLK_W*OUT_W-1:0] out_c,
    output logic                   done
);

    state_t                 state, state_nx;
    logic                   adv, accept, out_hs, last_out;
    logic                   s1_valid;
    logic [IN_W-1:0]        s1_row;
    logic [RW-1:0]          s1_idx;
    logic [BLK_W*OUT_W-1:0] fa, fb, fc;

    // Whole pipeline stalls only when a held output is refused
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = (state == ST_RUN) && adv;
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign last_out = out_hs && (out_row == RW'(ROWS - 1));
    assign busy     = (state != ST_IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_RUN;
            ST_RUN:   if (accept && (row_idx == RW'(ROWS - 1))) state_nx = ST_DRAIN;
            ST_DRAIN: if (last_out) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            row_idx   <= '0;
            s1_valid  <= 1'b0;
            s1_row    <= '0;
            s1_idx    <= '0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state == ST_DRAIN) && last_out;
            if ((state == ST_IDLE) && start)
                row_idx <= '0;
            else if (accept)
                row_idx <= row_idx + 1'b1;
            if (adv) begin
                s1_valid  <= accept;
                out_valid <= s1_valid;
                if (accept) begin
                    s1_row <= in_row;
                    s1_idx <= row_idx;
                end
                if (s1_valid) begin
                    out_row <= s1_idx;
                    out_a   <= fa;
                    out_b   <= fb;
                    out_c   <= fc;
                end
            end
        end
    end

    for (genvar j = 0; j < BLK_W; j++) begin : g_col
        hevc_fir8 #(
            .BIT_DEPTH(BIT_DEPTH),
            .OUT_W    (OUT_W)
        ) u_fir (
            .pix  (s1_row[j*BIT_DEPTH +: 8*BIT_DEPTH]),
            .res_a(fa[j*OUT_W +: OUT_W]),
            .res_b(fb[j*OUT_W +: OUT_W]),
            .res_c(fc[j*OUT_W +: OUT_W])
        );
    end

endmodule
